// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for MUL, MULHU, DIVU and REMU.
// Performs one shift-add or shift-subtract step per cycle on a shared 2*WIDTH accumulator.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             stall,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is sampled only in IDLE and is accepted when flush is low.
  // valid is high for exactly one cycle, in DONE, and only when flush is low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DIVZ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_rem;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     field;
  logic                 fire;

  // Multiply: lower half holds the multiplier, product shifts in from the top.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
  end

  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  always_comb begin
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   field = acc_q[WIDTH-1:0];
      2'b01:   field = acc_q[2*WIDTH-1:WIDTH];
      2'b10:   field = acc_q[WIDTH-1:0];
      default: field = acc_q[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          a_d   = src_a;
          b_d   = src_b;
          op_d  = op;
          cnt_d = '0;
          if (op[1] && (src_b == '0)) begin
            // Preload the RISC-V divide-by-zero answers: quotient all ones, remainder = dividend.
            acc_d   = {src_a, {WIDTH{1'b1}}};
            state_d = S_DIVZ;
          end else begin
            acc_d   = op[1] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{1'b0}}, src_b};
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[1] ? div_step : mul_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DIVZ: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (!flush) begin
          result_d = field;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // The new value is presented during DONE itself so it lines up with the valid pulse.
  assign fire        = (state_q == S_DONE) && !flush;
  assign valid       = fire;
  assign result      = fire ? field : result_q;
  assign busy        = (state_q == S_BUSY) || (state_q == S_DIVZ);
  assign stall       = ((state_q == S_IDLE) && start && !flush) || busy;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results,
// latency/stall/busy accounting, flush and reset mid-operation.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, result;
  logic         valid, busy, stall;
  logic [1:0]   dbg_state;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;
  logic         prev_valid = 1'b0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .result(result), .valid(valid), .busy(busy), .stall(stall),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == '0) ? {W{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // scoreboard
  always @(negedge clk) begin
    #1;
    if (valid) begin
      check_eq("valid_back_to_back", W'(prev_valid), '0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid_queue_depth", W'(exp_q.size()), W'(1));
      end else begin
        check_eq("result", result, exp_q.pop_front());
      end
      last_res = result;
    end
    prev_valid = valid;
  end

  // drivers
  task automatic accept_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic stall0);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 stall0 = stall;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic op_run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat);
    logic s0;
    int   lat, stalls, busys;
    exp_q.push_back(model(o, a, b));
    accept_op(o, a, b, s0);
    stalls = int'(s0);
    busys  = 0;
    lat    = 1;
    #1;
    while (!valid && lat < 100) begin
      stalls += int'(stall);
      busys  += int'(busy);
      @(negedge clk);
      lat++;
      #1;
    end
    check_eq("latency", W'(lat), W'(exp_lat));
    check_eq("stall_cycles", W'(stalls), W'(exp_lat));
    check_eq("busy_cycles", W'(busys), W'(exp_lat - 1));
    check_eq("stall_in_done", W'(stall), '0);
    @(negedge clk);
    #1;
    check_eq("valid_after_done", W'(valid), '0);
    check_eq("idle_after_done", W'(dbg_state), '0);
  endtask

  initial begin
    logic         s0;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           vcount;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_result", result, '0);
    check_eq("reset_valid", W'(valid), '0);
    check_eq("reset_busy", W'(busy), '0);
    check_eq("reset_stall", W'(stall), '0);
    check_eq("reset_state", W'(dbg_state), '0);

    op_run(2'b00, 32'd7, 32'd6, 33);
    op_run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    op_run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    op_run(2'b10, 32'd100, 32'd7, 33);
    op_run(2'b11, 32'd100, 32'd7, 33);
    op_run(2'b10, 32'h8000_0000, 32'd1, 33);
    op_run(2'b10, 32'd5, 32'd0, 2);
    op_run(2'b11, 32'd5, 32'd0, 2);

    // flush while BUSY
    accept_op(2'b00, 32'd3, 32'd4, s0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_busy_state", W'(dbg_state), '0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 vcount += int'(valid);
    end
    check_eq("flush_no_valid", W'(vcount), '0);
    check_eq("flush_result_hold", result, last_res);
    op_run(2'b10, 32'd9, 32'd2, 33);

    // flush while DONE
    accept_op(2'b00, 32'd11, 32'd13, s0);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("flush_done_state", W'(dbg_state), W'(3));
    check_eq("flush_done_valid", W'(valid), '0);
    check_eq("flush_done_result", result, last_res);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_done_idle", W'(dbg_state), '0);
    check_eq("flush_done_result_after", result, last_res);

    // reset mid-divide
    accept_op(2'b10, 32'd1000, 32'd3, s0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("rst_mid_result", result, '0);
    check_eq("rst_mid_valid", W'(valid), '0);
    check_eq("rst_mid_busy", W'(busy), '0);
    check_eq("rst_mid_stall", W'(stall), '0);
    last_res = '0;
    op_run(2'b00, 32'd2, 32'd3, 33);

    // random mix
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      op_run(ro, ra, rb, (ro[1] && rb == '0) ? 2 : 33);
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide unit plus its controlling FSM. Serves the unsigned RV32M subset: MUL, MULHU, DIVU, REMU.
- Sits beside the ALU in the Execute stage and shares operand/forwarding muxes with it.
- Issues a stall to the hazard unit while an operation is in progress. Presents a one-cycle valid result to the EX/MEM register when done.
- One shift-add or shift-subtract step per cycle; one shared 2*WIDTH-bit accumulator datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  Execute-stage instruction is an M-op; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- src_a  input  WIDTH  multiplicand or dividend (post-forwarding).
- src_b  input  WIDTH  multiplier or divisor (post-forwarding).
- flush  input  1  kill the in-flight op (branch mispredict or trap).
- result  output  WIDTH  registered result; holds last value until overwritten.
- valid  output  1  result valid; pulses high for exactly one cycle.
- busy  output  1  high in BUSY and DIVZ states.
- stall  output  1  combinational: (state==IDLE & start & !flush) | busy. Drives the IF/ID/EX stall.

Behaviour:
- Reset: a synchronous reset on clk with rst=1 forces the following on that edge, regardless of state or other inputs:
  - state=IDLE, counter=0, accumulator=0, latched operands=0, latched op=0.
  - result=0, valid=0, busy=0, stall=0.
- States: IDLE, BUSY, DIVZ, DONE.
- IDLE:
  - If start=1 and flush=0: latch src_a, src_b and op; clear counter.
  - If op is DIVU/REMU and src_b==0, go to DIVZ. Otherwise initialise the accumulator and go to BUSY.
  - start=0 or flush=1: stay in IDLE.
- BUSY:
  - Performs one step per cycle. Multiply: conditional add of the multiplicand, then shift right. Divide: restoring shift-subtract, quotient bit in.
  - counter increments each cycle. On the cycle with counter==WIDTH-1, go to DONE.
  - Exactly WIDTH cycles are spent in BUSY.
- DIVZ: single cycle, then DONE. RISC-V divide-by-zero values: DIVU result=all ones; REMU result=latched src_a.
- DONE:
  - valid=1 and result is loaded with the selected field:
    - MUL: low WIDTH bits of product.
    - MULHU: high WIDTH bits of product.
    - DIVU: quotient.
    - REMU: remainder.
  - stall=0. Next state is always IDLE.
  - start is ignored in DONE; a back-to-back M-op is accepted in the following IDLE cycle.
- Latency:
  - Accept edge T. DONE is entered at T+WIDTH+1, giving valid=1 in cycle T+33 for WIDTH=32.
  - Divide-by-zero: valid=1 in cycle T+2.
- Arithmetic:
  - All operands are unsigned. Product is 2*WIDTH bits with no overflow flag.
  - Quotient and remainder obey a = q*b + r with r < b.
- Flush:
  - In BUSY/DIVZ: the next edge returns to IDLE, valid stays 0, result is unchanged, and counter is cleared.
  - In DONE: the valid pulse is suppressed (valid=0) and result is unchanged.
  - In IDLE with start=1: the op is not accepted.
- Simultaneous rst and flush: rst wins.
- Operands src_a/src_b may change while in BUSY without affecting the result, because only latched copies are used.
- valid is never high in two consecutive cycles.

Test Plan:
- Reset, then MUL src_a=7, src_b=6, start for 1 cycle -> stall high for 33 cycles, valid=1 in cycle T+33 with result=42, then valid=0 and state=IDLE.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result=0xFFFFFFFE. Follow with MUL on the same operands -> result=0x00000001.
- DIVU 100/7 -> result=14; REMU 100/7 -> result=2. Also DIVU 0x80000000/1 -> 0x80000000.
- DIVU 5/0 -> valid at T+2 with result=0xFFFFFFFF. REMU 5/0 -> result=5. busy high for exactly 1 cycle.
- MUL 3*4, flush asserted 10 cycles after accept -> no valid pulse and result keeps its prior value. Then DIVU 9/2 -> result=4 at T'+33.
- DIVU in progress, rst at cycle 20 -> next cycle result=0, valid=0, busy=0, stall=0. Then a new MUL 2*3 -> result=6.
